// File: rtl/ram_sync_init.sv
// Parametrised synchronous single-port RAM with registered read data, a clear engine
// that walks every word to INIT_VAL after reset or clr_req, and out-of-range error strobes.
module ram_sync_init #(
    parameter int unsigned          DATA_W   = 8,
    parameter int unsigned          ADDR_W   = 10,
    parameter int unsigned          DEPTH    = 1024,
    parameter logic [DATA_W-1:0]    INIT_VAL = '0,
    parameter bit                   RDW_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              clr_req,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                we_c;
    logic [IDX_W-1:0]    waddr_c;
    logic [DATA_W-1:0]   wdata_c;
    logic                rd_c;
    logic                err_d;
    logic                load_din_c;
    logic                in_range_c;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    // A full-depth array has no unreachable addresses.
    if (DEPTH == (1 << ADDR_W)) begin : g_full
        assign in_range_c = 1'b1;
    end else begin : g_partial
        assign in_range_c = (addr < ADDR_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_c       = 1'b0;
        waddr_c    = IDX_W'(cnt_q);
        wdata_c    = INIT_VAL;
        rd_c       = 1'b0;
        err_d      = 1'b0;
        load_din_c = 1'b0;
        case (state_q)
            S_CLEAR: begin
                we_c  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                // clr_req outranks any access presented in the same cycle
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (sel) begin
                    err_d = !in_range_c;
                    if (wr) begin
                        we_c       = in_range_c;
                        waddr_c    = IDX_W'(addr);
                        wdata_c    = din;
                        load_din_c = RDW_MODE && in_range_c;
                    end else begin
                        rd_c = 1'b1;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Array is left untouched on a reset edge; the clear engine rewrites it afterwards.
    always_ff @(posedge clk) begin
        if (!rst && we_c) begin
            mem[waddr_c] <= wdata_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b1;
        end else begin
            dout_valid <= rd_c;
            err        <= err_d;
            busy       <= (state_d == S_CLEAR);
            if (rd_c) begin
                dout <= in_range_c ? mem[IDX_W'(addr)] : '0;
            end else if (load_din_c) begin
                dout <= din;
            end
        end
    end

endmodule

// File: tb/tb_ram_sync_init.sv
// Scoreboard bench for ram_sync_init: two instances (read-first and write-first) share
// one stimulus stream; a behavioural model queues expected outputs, monitors compare.
module tb_ram_sync_init;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 20;
    localparam logic [DW-1:0] INIT = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          clr_req;
    logic [DW-1:0] dout0, dout1;
    logic          dv0, dv1, busy0, busy1, err0, err1;

    always #5 clk = ~clk;

    ram_sync_init #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .INIT_VAL(INIT), .RDW_MODE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr), .din(din), .clr_req(clr_req),
        .dout(dout0), .dout_valid(dv0), .busy(busy0), .err(err0)
    );

    ram_sync_init #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .INIT_VAL(INIT), .RDW_MODE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr), .din(din), .clr_req(clr_req),
        .dout(dout1), .dout_valid(dv1), .busy(busy1), .err(err1)
    );

    typedef struct packed {
        logic          busy;
        logic          valid;
        logic          err;
        logic [DW-1:0] dout;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    // Reference model: the array plus "cycles of clearing still to go".
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left = 0;
    logic [DW-1:0] m_dout [2];
    logic          m_valid = 1'b0;
    logic          m_err = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    bit done = 1'b0;

    function automatic void model_edge(input logic r, s, w, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d, input logic c);
        bit oor;
        oor = (int'(a) >= int'(DEPTH));
        if (r) begin
            m_left = DEPTH;
            m_dout[0] = '0;
            m_dout[1] = '0;
            m_valid = 1'b0;
            m_err = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = INIT;
            end
            m_valid = 1'b0;
            m_err = 1'b0;
        end else if (c) begin
            m_left = DEPTH;
            m_valid = 1'b0;
            m_err = 1'b0;
        end else if (s) begin
            m_err = oor;
            if (w) begin
                m_valid = 1'b0;
                if (!oor) begin
                    m_mem[a] = d;
                    m_dout[1] = d;
                end
            end else begin
                m_valid = 1'b1;
                m_dout[0] = oor ? '0 : m_mem[a];
                m_dout[1] = m_dout[0];
            end
        end else begin
            m_valid = 1'b0;
            m_err = 1'b0;
        end
    endfunction

    task automatic step(input logic r, s, w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic c);
        @(negedge clk);
        rst = r; sel = s; wr = w; addr = a; din = d; clr_req = c;
        model_edge(r, s, w, a, d, c);
        exp_q0.push_back('{busy: (m_left > 0), valid: m_valid, err: m_err, dout: m_dout[0]});
        exp_q1.push_back('{busy: (m_left > 0), valid: m_valid, err: m_err, dout: m_dout[1]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic check(input int id, input exp_t e, input logic b, v, er, input logic [DW-1:0] d);
        n_vec++;
        if ({b, v, er, d} !== e) begin
            n_bad++;
            $display("FAIL cyc%0d dut%0d busy/valid/err/dout got %b/%b/%b/%h want %b/%b/%b/%h",
                     cyc, id, b, v, er, d, e.busy, e.valid, e.err, e.dout);
        end
    endtask

    // Monitor: each queued expectation describes the outputs after the next rising edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check(0, e, busy0, dv0, err0, dout0);
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check(1, e, busy1, dv1, err1, dout1);
            end
        end
    end

    initial begin
        logic [AW-1:0] ra;
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        m_dout[0] = '0;
        m_dout[1] = '0;
        rst = 1'b1; sel = 1'b0; wr = 1'b0; addr = '0; din = '0; clr_req = 1'b0;
        void'($urandom(35));

        // Reset, then writes to addr 3 while clearing must be ignored
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 1'b1, 1'b1, AW'(3), 8'h55, 1'b0);
        idle(2);

        // Read every address, including the out-of-range ones
        for (int a = 0; a < 32; a++) step(1'b0, 1'b1, 1'b0, AW'(a), '0, 1'b0);

        // Write pattern, then pseudo-random readback
        for (int a = 0; a < int'(DEPTH); a++) step(1'b0, 1'b1, 1'b1, AW'(a), DW'((2 * a) % 256), 1'b0);
        for (int i = 0; i < 20; i++) begin
            ra = AW'($urandom_range(DEPTH - 1, 0));
            step(1'b0, 1'b1, 1'b0, ra, '0, 1'b0);
        end

        // Out-of-range write then read
        step(1'b0, 1'b1, 1'b1, AW'(25), 8'h7E, 1'b0);
        step(1'b0, 1'b1, 1'b0, AW'(25), '0, 1'b0);
        idle(1);

        // Read-during-write behaviour
        step(1'b0, 1'b1, 1'b1, AW'(9), 8'h99, 1'b0);
        step(1'b0, 1'b1, 1'b0, AW'(9), '0, 1'b0);
        step(1'b0, 1'b1, 1'b1, AW'(7), 8'h3C, 1'b0);
        step(1'b0, 1'b1, 1'b0, AW'(7), '0, 1'b0);
        idle(1);

        // clr_req wins over a simultaneous write
        step(1'b0, 1'b1, 1'b1, AW'(5), 8'h11, 1'b0);
        step(1'b0, 1'b1, 1'b1, AW'(5), 8'h22, 1'b1);
        idle(DEPTH);
        step(1'b0, 1'b1, 1'b0, AW'(5), '0, 1'b0);

        // Reset in the middle of a clear
        step(1'b0, 1'b1, 1'b1, AW'(2), 8'h44, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(8);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 1'b1, 1'b1, AW'(2), 8'h66, 1'b0);
        step(1'b0, 1'b1, 1'b0, AW'(2), '0, 1'b0);

        // Random traffic with occasional clears and resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(199, 0) == 0), ($urandom_range(3, 0) != 0), $urandom_range(1, 0) == 1,
                 AW'($urandom), DW'($urandom), ($urandom_range(63, 0) == 0));
        end
        idle(3);

        @(posedge clk);
        #2;
        done = 1'b1;
        n_vec++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain leftover expectations got %0d/%0d want 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_sync_init.md
Name: ram_sync_init

Overview:
Parametrised synchronous single-port RAM. It is the clocked successor to the 1024x8 select/wr RAM and is generalised in data width, address width, depth and read-during-write mode. A built-in clear engine walks every word to a programmable init value after reset or on request. It adds registered read data with a valid strobe, a busy flag and out-of-range error reporting, and is the storage primitive for buffers and lookup tables in the memory subsystem.

Parameters:
DATA_W, 8, data word width in bits (1..64)
ADDR_W, 10, address width in bits (1..16)
DEPTH, 1024, number of words; 1 <= DEPTH <= 2**ADDR_W
INIT_VAL, 0, DATA_W-bit value written to every word by the clear engine
RDW_MODE, 0, read-during-write result: 0 = read-first (old data), 1 = write-first (new data)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
sel  input  1  access request strobe
wr  input  1  1 = write, 0 = read; qualified by sel
addr  input  ADDR_W  word address
din  input  DATA_W  write data
clr_req  input  1  start a clear of the whole array (single-cycle pulse)
dout  output  DATA_W  registered read data
dout_valid  output  1  one-cycle strobe: dout updated by a read
busy  output  1  clear engine running; accesses ignored
err  output  1  one-cycle strobe: accepted access had addr >= DEPTH

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (rst sampled on rising edge of clk).
- Reset: at an edge with rst=1, the block sets dout=0, dout_valid=0, err=0, busy=1, state=CLEAR and clear counter cnt=0. Array contents are not touched on that edge.
- States: CLEAR, READY.
- CLEAR:
  - Each edge with rst=0 writes mem[cnt]=INIT_VAL and increments cnt.
  - On the edge that writes cnt=DEPTH-1, the state goes to READY and busy falls.
  - busy is therefore high for exactly DEPTH cycles after rst deasserts.
  - sel, wr, addr, din and clr_req are ignored; dout holds its value; dout_valid=0 and err=0.
- READY:
  - An access is accepted when sel=1 at the edge.
  - Write (wr=1): mem[addr]=din at that edge. dout_valid=0. dout is unchanged, except as defined under read-during-write below.
  - Read (wr=0): dout=mem[addr] at that edge and dout_valid=1 for exactly that following cycle. Read latency is 1 clock.
  - Idle (sel=0): dout holds its value and dout_valid=0.
- Out of range (addr >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - A write is dropped.
  - A read returns dout=0 with dout_valid=1.
  - err=1 for one cycle in both cases.
- clr_req=1 in READY: the state goes to CLEAR with cnt=0 and busy=1 at that edge. Any sel access in the same cycle is ignored (clr_req has priority). The clear takes DEPTH cycles after that edge.
- Read-during-write: the port is single-port, so it is defined only for the registered-read interaction. A read of address A in the cycle directly after a write to A always returns the new data.
  - RDW_MODE affects only the write cycle itself: on a write, RDW_MODE=1 also loads dout=din with dout_valid=0.
  - RDW_MODE=0 leaves dout unchanged on a write.
- Reset mid-clear or mid-operation: rst wins over everything, and the clear restarts from cnt=0. Partially cleared contents are overwritten by the new clear.
- Address arithmetic: cnt is ADDR_W+1 bits so DEPTH=2**ADDR_W terminates without wrap. No wrap-around of addr is performed.
- Storage: an inferred array reg [DATA_W-1:0] mem[0:DEPTH-1]. No asynchronous read path.

Test Plan:
- Reset/clear (DEPTH=16, INIT_VAL=8'hA5): pulse rst for 1 cycle -> busy high exactly 16 cycles. Afterwards, a read of every address returns 8'hA5 with dout_valid pulsing once per read, 1-cycle latency.
- Write/readback (default params): write (2k)%256 to all 1024 addresses, then read 20 pseudo-random addresses (seed 35) -> dout == (2*addr)%256 one cycle after each request.
- Accesses while busy: issue writes to addr 3 of 8'h55 during CLEAR -> after busy falls, read addr 3 returns INIT_VAL, not 8'h55. dout_valid stays 0 throughout CLEAR.
- clr_req priority: in READY, write 8'h11 to addr 5, then assert clr_req together with sel=1,wr=1,addr=5,din=8'h22 -> busy rises next cycle. After DEPTH cycles, a read of addr 5 returns INIT_VAL.
- Out of range (ADDR_W=5, DEPTH=20): write 8'h7E to addr 25 -> err=1 for one cycle, no array change. Read addr 25 -> dout=0, dout_valid=1, err=1.
- RDW modes: with RDW_MODE=0, write 8'h3C to addr 7 while dout=8'h99 -> dout stays 8'h99. With RDW_MODE=1 -> dout=8'h3C, dout_valid=0. In both modes, a read of addr 7 on the next cycle returns 8'h3C.
- Reset mid-clear: assert rst at clear cycle 8 of 16 -> cnt restarts, and busy stays high 16 further cycles after rst deasserts.
